// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    // Two-bit encoding leaves spare codes so a corrupted state has somewhere to recover from.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping 3->0.
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] j;
        win     = '0;
        win_idx = '0;
        any     = |req;
        j       = '0;
        // Walk from the farthest offset back to ptr so the nearest hit is the last write.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (req[j]) begin
                win     = '0;
                win[j]  = 1'b1;
                win_idx = j;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter with registered one-hot grant, valid/ready handshake and a
// saturating count of completed grants.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned RESET_PTR = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             ready,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [CNT_W-1:0] gnt_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] pick_ptr;
    logic [NREQ-1:0]  pick_win;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             handshake;

    assign handshake = (state_q == StGrant) && valid_q && ready;

    // On a handshake the next winner is chosen with the pointer that is about to be stored.
    assign pick_ptr = handshake ? idx_q + IDX_W'(1) : ptr_q;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                if (pick_any) begin
                    gnt_d   = pick_win;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (handshake) begin
                    ptr_d = pick_ptr;
                    if (~&cnt_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (pick_any) begin
                        gnt_d   = pick_win;
                        idx_d   = pick_idx;
                        valid_d = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= IDX_W'(RESET_PTR);
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign idx     = idx_q;
    assign valid   = valid_q;
    assign gnt_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a pick-function vector table plus hand-written
// multi-cycle sequences against two arbiter instances (8-bit and 2-bit counters).
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic [7:0] gnt_cnt;
    logic [3:0] gnt2;
    logic [1:0] idx2;
    logic       valid2;
    logic [1:0] gnt_cnt2;

    logic [3:0] t_req;
    logic [1:0] t_ptr;
    logic [3:0] t_win;
    logic [1:0] t_idx;
    logic       t_any;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter4 #(.RESET_PTR(0), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (ready),
        .gnt     (gnt),
        .idx     (idx),
        .valid   (valid),
        .gnt_cnt (gnt_cnt)
    );

    rr_arbiter4 #(.RESET_PTR(0), .CNT_W(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (ready),
        .gnt     (gnt2),
        .idx     (idx2),
        .valid   (valid2),
        .gnt_cnt (gnt_cnt2)
    );

    rr_pick4 u_pick (
        .req     (t_req),
        .ptr     (t_ptr),
        .win     (t_win),
        .win_idx (t_idx),
        .any     (t_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] ptr;
        logic [3:0] win;
        logic [1:0] idx;
        logic       any;
    } pick_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string name, input logic [1:0] exp_idx);
        logic [3:0] exp_gnt;
        exp_gnt = 4'b0001 << exp_idx;
        check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
        check({name, " idx"}, 32'(idx), 32'(exp_idx));
        check({name, " valid"}, 32'(valid), 32'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, " gnt"}, 32'(gnt), 32'd0);
        check({name, " idx"}, 32'(idx), 32'd0);
        check({name, " valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        pick_vec_t vecs[12];
        vecs[0]  = '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0001, 2'd0, 4'b0001, 2'd0, 1'b1};
        vecs[2]  = '{4'b1111, 2'd0, 4'b0001, 2'd0, 1'b1};
        vecs[3]  = '{4'b1111, 2'd1, 4'b0010, 2'd1, 1'b1};
        vecs[4]  = '{4'b1111, 2'd3, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{4'b0011, 2'd3, 4'b0001, 2'd0, 1'b1};
        vecs[6]  = '{4'b0110, 2'd3, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b1001, 2'd1, 4'b1000, 2'd3, 1'b1};
        vecs[8]  = '{4'b1001, 2'd0, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{4'b0100, 2'd3, 4'b0100, 2'd2, 1'b1};
        vecs[10] = '{4'b1010, 2'd2, 4'b1000, 2'd3, 1'b1};
        vecs[11] = '{4'b0000, 2'd2, 4'b0000, 2'd0, 1'b0};

        rst   = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            t_req = vecs[i].req;
            t_ptr = vecs[i].ptr;
            #1;
            check($sformatf("pick[%0d] win", i), 32'(t_win), 32'(vecs[i].win));
            check($sformatf("pick[%0d] idx", i), 32'(t_idx), 32'(vecs[i].idx));
            check($sformatf("pick[%0d] any", i), 32'(t_any), 32'(vecs[i].any));
        end

        tick();
        check_idle("reset");
        check("reset cnt", 32'(gnt_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // Full rotation; the 2-bit counter instance shows saturation alongside.
        req   = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_grant($sformatf("rot[%0d]", k), 2'(k % 4));
            check($sformatf("rot[%0d] cnt", k), 32'(gnt_cnt), 32'(k));
            if (k >= 1) begin
                check($sformatf("sat[%0d] cnt", k), 32'(gnt_cnt2), 32'((k > 3) ? 3 : k));
            end
        end
        tick();
        check("rot cnt6", 32'(gnt_cnt), 32'd6);
        check_grant("rot[6]", 2'd2);

        // Asynchronous reset mid-cycle while granting.
        #3;
        rst = 1'b1;
        #1;
        check_idle("async rst");
        check("async rst cnt", 32'(gnt_cnt), 32'd0);
        check("async rst cnt2", 32'(gnt_cnt2), 32'd0);
        req   = 4'b0000;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_idle("idle no req");

        // Single request held under backpressure, then re-granted after handshake.
        req = 4'b0100;
        tick();
        check_grant("single", 2'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_grant($sformatf("single hold[%0d]", k), 2'd2);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("single cnt", 32'(gnt_cnt), 32'd1);
        check_grant("single regrant", 2'd2);

        // ptr is now 3 after granting idx 2: wrap to 0, then 1.
        req   = 4'b0011;
        ready = 1'b1;
        tick();
        check_grant("wrap0", 2'd0);
        tick();
        ready = 1'b0;
        check_grant("wrap1", 2'd1);
        check("wrap cnt", 32'(gnt_cnt), 32'd3);

        // Grant on idx 1 must survive req changing under backpressure.
        req = 4'b1000;
        tick();
        check_grant("hold a", 2'd1);
        tick();
        check_grant("hold b", 2'd1);
        check("hold cnt", 32'(gnt_cnt), 32'd3);
        ready = 1'b1;
        tick();
        check_grant("after hold", 2'd3);
        check("after hold cnt", 32'(gnt_cnt), 32'd4);
        req = 4'b0000;
        tick();
        check_idle("drain");
        check("drain cnt", 32'(gnt_cnt), 32'd5);

        // ready while idle must not move ptr or count.
        tick();
        tick();
        check_idle("ready idle");
        check("ready idle cnt", 32'(gnt_cnt), 32'd5);
        ready = 1'b0;
        req   = 4'b1111;
        tick();
        check_grant("ptr after idle", 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
